// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder: FSM state encodings and the
// default operand width.
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  // Default operand/sum width in bits (legal range 2..32)
  localparam int DEFAULT_WIDTH = 4;

  // Controller states; encodings are fixed so other tools can decode them
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle of the bit-serial adder.
//   start       : request to begin an addition
//   A, B, ci    : operands and carry-in, captured on an accepted start
//   s, co       : sum and carry-out, valid from done until the next start
//   busy        : high while the addition is running
//   done        : single-cycle pulse marking s/co valid
// Modports: master (requester side), slave (adder side).
// -----------------------------------------------------------------------------
interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ci;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, ci,
    input  s, co, busy, done
  );

  modport slave (
    input  start, A, B, ci,
    output s, co, busy, done
  );

endinterface : serial_adder_if

// File: rtl/serial_adder_add1bit.sv
// -----------------------------------------------------------------------------
// add1bit
// One-bit full adder cell used by the serial adder datapath.
//   A, B : operand bits
//   ci   : carry-in
//   s    : sum bit      = A ^ B ^ ci
//   co   : carry-out    = A&B | ci&(A^B)
// -----------------------------------------------------------------------------
module add1bit (
  input  logic A,
  input  logic B,
  input  logic ci,
  output logic s,
  output logic co
);

  logic half_sum;

  // Full-add equations; half_sum is shared between sum and carry
  always_comb begin
    half_sum = A ^ B;
    s        = half_sum ^ ci;
    co       = (A & B) | (ci & half_sum);
  end

endmodule : add1bit

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in one bit per
// clock, LSB first, using a single full-adder cell.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_adder_if slave modport (start/A/B/ci in, s/co/busy/done out)
// An operation takes WIDTH RUN cycles; done pulses in the cycle after the
// last RUN cycle. A start in the DONE cycle chains a new operation directly.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  serial_adder_if.slave   bus
);

  localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   s_sh;
  logic               carry;
  logic               load;
  logic               shift;
  logic               sum_bit;
  logic               carry_bit;

  // Single full-adder cell works on the current LSBs and the carry flop
  add1bit u_add1bit (
    .A  (a_sh[0]),
    .B  (b_sh[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_bit)
  );

  // Next-state logic plus load/shift strobes for the datapath
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        // start is deliberately not looked at here
        shift = 1'b1;
        if (cnt == LAST) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register and serial datapath (operand/sum shifters, carry, counter)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_sh  <= bus.A;
        b_sh  <= bus.B;
        carry <= bus.ci;
        cnt   <= '0;
        s_sh  <= '0;
      end else if (shift) begin
        // Sum enters at the MSB so after WIDTH shifts bit 0 sits at bit 0
        a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
        b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
        s_sh  <= {sum_bit, s_sh[WIDTH-1:1]};
        carry <= carry_bit;
        cnt   <= cnt + CNT_W'(1);
      end else begin
        a_sh  <= a_sh;
        b_sh  <= b_sh;
        s_sh  <= s_sh;
        carry <= carry;
        cnt   <= cnt;
      end
    end
  end

  // Status flags decoded straight from the state register
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      IDLE:    begin bus.busy = 1'b0; bus.done = 1'b0; end
      RUN:     begin bus.busy = 1'b1; bus.done = 1'b0; end
      DONE:    begin bus.busy = 1'b0; bus.done = 1'b1; end
      default: begin bus.busy = 1'b0; bus.done = 1'b0; end
    endcase
  end

  // Result registers drive the outputs directly; the carry flop is co
  assign bus.s  = s_sh;
  assign bus.co = carry;

endmodule : serial_adder
